image_ram_reader: RTL and testbench

IMAGE_RAM_READER -- requirements
Module: image_ram_reader

---
 rtl/image_ram_reader.sv | 120 ++++++++++++
 tb/tb_image_ram_reader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/image_ram_reader.sv
// image_ram_reader: streams a burst of bytes out of a synchronous-read RAM.
// Reads are issued against a credit of two (one in flight plus a 2-entry
// output FIFO). The byte leaving the FIFO in the current cycle returns its
// credit immediately, so a continuously ready sink sees one byte per cycle.
module image_ram_reader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    localparam logic [ADDR_W:0]   LEN_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [ADDR_W:0]          iss_cnt_q, iss_cnt_d;
    logic [ADDR_W:0]          acc_cnt_q, acc_cnt_d;
    logic [ADDR_W-1:0]        last_addr_q;
    logic                     pend_q;
    logic [1:0][DATA_W-1:0]   mem_q;
    logic                     wr_ptr_q, rd_ptr_q;
    logic [1:0]               fifo_cnt_q;

    logic                     issue, pop;
    logic [2:0]               occ, lim;

    // Credit check: in-flight read plus buffered bytes, minus this cycle's pop.
    always_comb begin
        out_valid = (fifo_cnt_q != 2'd0);
        out_data  = mem_q[rd_ptr_q];
        pop       = out_valid && out_ready;
        occ       = {1'b0, fifo_cnt_q} + {2'b00, pend_q};
        lim       = 3'd2 + {2'b00, pop};
        issue     = (state_q == FETCH) && (iss_cnt_q != '0) && (occ < lim);
        rdaddress = issue ? addr_q : last_addr_q;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end

    // Next-state and counter updates.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        iss_cnt_d = iss_cnt_q;
        acc_cnt_d = acc_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = start_addr;
                    iss_cnt_d = len;
                    acc_cnt_d = len;
                    state_d   = (len == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (issue) begin
                    addr_d    = addr_q + ADDR_ONE;
                    iss_cnt_d = iss_cnt_q - LEN_ONE;
                end
                if (pop) begin
                    acc_cnt_d = acc_cnt_q - LEN_ONE;
                    if (acc_cnt_q == LEN_ONE) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state, counters and the held read address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            iss_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            last_addr_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            iss_cnt_q <= iss_cnt_d;
            acc_cnt_q <= acc_cnt_d;
            pend_q    <= issue;
            if (issue) last_addr_q <= addr_q;
        end
    end

    // Output FIFO: capture q one cycle after the RAM sampled an issued address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (pend_q) begin
                mem_q[wr_ptr_q] <= q;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + {1'b0, pend_q} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_image_ram_reader.sv
// Bench for image_ram_reader: RAM model holds addr&0xFF, a scoreboard queue
// carries expected bytes from each start to the output monitor.
module tb_image_ram_reader;

    localparam int AW = 10;
    localparam int DW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   len;
    logic [AW-1:0] rdaddress;
    logic [DW-1:0] q;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] ra_s;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    image_ram_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .len(len), .rdaddress(rdaddress), .q(q), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM with RAM[i] = i & 0xFF; address taken mid-cycle.
    always @(negedge clock) ra_s <= rdaddress;
    always @(posedge clock) q <= ra_s[DW-1:0];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor: data order via scoreboard, stability while stalled.
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("extra_byte", 32'd1, 32'd0);
                else check("data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    function automatic logic ready_pat(input int mode, input int n);
        logic [3:0] pat;
        pat = 4'b1001;
        if (mode == 0) return 1'b1;
        return pat[3 - (n % 4)];
    endfunction

    task automatic run_burst(input int a, input int l, input int mode, input bit inj);
        int first, last, xfers, dones, done_n, busy_c;
        first = -1; last = -1; xfers = 0; dones = 0; done_n = -1; busy_c = 0;
        @(posedge clock); #1;
        start      = 1'b1;
        start_addr = a[AW-1:0];
        len        = l[AW:0];
        for (int k = 0; k < l; k++) exp_q.push_back(DW'((a + k) & 255));
        @(posedge clock); #1;
        start     = 1'b0;
        out_ready = ready_pat(mode, 0);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            if (out_valid && first < 0) first = n;
            if (out_valid && out_ready) begin xfers++; last = n; end
            if (busy) busy_c++;
            if (done) begin dones++; done_n = n; end
            if (done_n >= 0 && n == done_n + 1) begin
                check("idle_busy", {31'd0, busy}, 32'd0);
                break;
            end
            @(posedge clock); #1;
            out_ready = ready_pat(mode, n + 1);
            if (inj && n + 1 == 100) begin
                start = 1'b1; start_addr = 10'd500; len = 11'd7;
            end
            if (inj && n + 1 == 101) start = 1'b0;
        end
        out_ready = 1'b1;
        check("xfers", xfers, l);
        check("dones", dones, 1);
        check("sb_empty", exp_q.size(), 0);
        if (l == 0) begin
            check("no_valid", first, -1);
            check("done_len0", done_n, 0);
            check("busy_len0", busy_c, 1);
        end else begin
            if (mode == 0) begin
                check("latency", first, 2);
                check("no_bubble", last - first, l - 1);
            end
            check("done_after_last", done_n, last + 1);
            check("busy_cycles", busy_c, done_n + 1);
            check("rdaddr_hold", {22'd0, rdaddress}, (a + l - 1) % 1024);
        end
    endtask

    initial begin
        int xf;
        reset = 1'b1; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b1;
        @(negedge clock);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rdaddr", {22'd0, rdaddress}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        run_burst(0, 4, 0, 1'b0);
        run_burst(1022, 4, 0, 1'b0);
        run_burst(0, 16, 1, 1'b0);
        run_burst(0, 0, 0, 1'b0);
        run_burst(0, 1024, 0, 1'b1);

        // Reset in the middle of a 32-byte burst.
        @(posedge clock); #1;
        start = 1'b1; start_addr = '0; len = 11'd32;
        for (int k = 0; k < 32; k++) exp_q.push_back(DW'(k));
        @(posedge clock); #1 start = 1'b0;
        xf = 0;
        for (int n = 0; n < 100 && xf < 5; n++) begin
            @(negedge clock);
            if (out_valid && out_ready) xf++;
        end
        check("pre_rst_xfers", xf, 5);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data", {24'd0, out_data}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_rdaddr", {22'd0, rdaddress}, 32'd0);
        exp_q.delete();
        @(posedge clock); @(posedge clock); #1 reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            check("post_rst_valid", {31'd0, out_valid}, 32'd0);
            check("post_rst_busy", {31'd0, busy}, 32'd0);
        end
        run_burst(0, 2, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
